video_system_cpu_ocimem_access: RTL and testbench

- Downstream consumer of the debug-slave sysclk stage's jdo and take_*_ocimem_* strobes.
- Owns the on-chip debug memory (OCI RAM) shared between the JTAG path and the CPU's debug Avalon slave port.
- Produces MonDReg, monitor_ready and monitor_error, which feed back into the debug-slave TCK stage for scan-out.

---
 rtl/video_system_cpu_ocimem_access.sv | 224 ++++++++++++++++++++++
 tb/tb_video_system_cpu_ocimem_access.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_system_cpu_ocimem_access.sv
// OCI debug RAM shared by the JTAG debug path and the CPU debug Avalon slave.
// Optional RAM parity protection: define VIDEO_SYSTEM_CPU_OCIMEM_PARITY_EN.
module video_system_cpu_ocimem_access #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic              debugaccess,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef VIDEO_SYSTEM_CPU_OCIMEM_PARITY_EN
  localparam int RW = 33;
`else
  localparam int RW = 32;
`endif
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    J_RD,
    J_CAP,
    AV_RD
  } state_t;

  state_t state, state_nx;

  logic [RW-1:0]     mem [DEPTH];
  logic [RW-1:0]     ram_q;
  logic [RW-1:0]     ram_wdata;
  logic [31:0]       wdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

  logic        pa, pb, pn;
  logic [37:0] pjdo_a, pjdo_b;
  logic        rd_inc;
  logic        av_reg_q;
  logic [ADDR_W-1:0] av_off_q;

  logic        is_idle, pend_any, jwork;
  logic        sel_pa, sel_pb, sel_pn;
  logic        sel_la, sel_lb, sel_ln;
  logic        srv_a, srv_b, srv_n;
  logic        defer_a, defer_b, defer_n;
  logic        drop_a, drop_b, drop_n;
  logic [37:0] a_jdo, b_jdo;
  logic        av_rd_acc, av_wr_acc;
  logic        av_reg_wr0;
  logic        set_rdy, set_err, clr_st;
  logic        par_err;
  logic        unused_bits;

  assign is_idle  = (state == IDLE);
  assign pend_any = pa | pb | pn;
  assign jwork    = pend_any | take_action_ocimem_a
                  | take_action_ocimem_b
                  | take_no_action_ocimem_a;

  // Deferred work drains before any live strobe is looked at.
  assign sel_pa = is_idle & pa;
  assign sel_pb = is_idle & ~pa & pb;
  assign sel_pn = is_idle & ~pa & ~pb & pn;
  assign sel_la = is_idle & ~pend_any & take_action_ocimem_a;
  assign sel_lb = is_idle & ~pend_any & ~take_action_ocimem_a
                & take_action_ocimem_b;
  assign sel_ln = is_idle & ~pend_any & ~take_action_ocimem_a
                & ~take_action_ocimem_b & take_no_action_ocimem_a;

  assign srv_a = sel_pa | sel_la;
  assign srv_b = sel_pb | sel_lb;
  assign srv_n = sel_pn | sel_ln;

  assign a_jdo = sel_pa ? pjdo_a : jdo;
  assign b_jdo = sel_pb ? pjdo_b : jdo;

  assign defer_a = take_action_ocimem_a & ~sel_la;
  assign defer_b = take_action_ocimem_b & ~sel_lb;
  assign defer_n = take_no_action_ocimem_a & ~sel_ln;
  assign drop_a  = defer_a & pa & ~sel_pa;
  assign drop_b  = defer_b & pb & ~sel_pb;
  assign drop_n  = defer_n & pn & ~sel_pn;

  assign av_rd_acc = is_idle & ~jwork & av_read;
  assign av_wr_acc = is_idle & ~jwork & av_write & ~av_read;
  assign av_reg_wr0 = av_wr_acc & av_address[ADDR_W]
                    & (av_address[ADDR_W-1:0] == '0);

  assign clr_st  = srv_a & a_jdo[34];
  assign set_rdy = av_reg_wr0 & av_writedata[0];
  assign set_err = (av_reg_wr0 & av_writedata[1])
                 | drop_a | drop_b | drop_n | par_err;

  assign ram_we = srv_b
                | (av_wr_acc & ~av_address[ADDR_W] & debugaccess);
  assign ram_addr = (av_rd_acc | av_wr_acc)
                  ? av_address[ADDR_W-1:0] : MonAReg;
  assign wdata = srv_b ? b_jdo[34:3] : av_writedata;

`ifdef VIDEO_SYSTEM_CPU_OCIMEM_PARITY_EN
  assign ram_wdata = {^wdata, wdata};
  assign par_err = (state == J_CAP || (state == AV_RD && !av_reg_q))
                 && (^ram_q);
`else
  assign ram_wdata = wdata;
  assign par_err = 1'b0;
`endif

  assign unused_bits = ^{a_jdo[37], a_jdo[33:ADDR_W+10], a_jdo[9:0],
                         b_jdo[37:35], b_jdo[2:0]};

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ram_q <= '0;
    else
      ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (srv_n || (srv_a && a_jdo[36]))
          state_nx = J_RD;
        else if (av_rd_acc)
          state_nx = AV_RD;
      end
      J_RD:    state_nx = J_CAP;
      J_CAP:   state_nx = IDLE;
      AV_RD:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    av_waitrequest = 1'b0;
    av_readdata    = '0;
    if (state == AV_RD) begin
      if (!av_reg_q)
        av_readdata = ram_q[31:0];
      else if (av_off_q == '0)
        av_readdata = {30'b0, monitor_error, monitor_ready};
      else if (av_off_q == ONE)
        av_readdata = MonDReg;
    end else begin
      av_waitrequest = (av_read | av_write) & ~av_wr_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pa     <= 1'b0;
      pb     <= 1'b0;
      pn     <= 1'b0;
      pjdo_a <= '0;
      pjdo_b <= '0;
    end else begin
      pa <= sel_pa ? defer_a : (pa | defer_a);
      pb <= sel_pb ? defer_b : (pb | defer_b);
      pn <= sel_pn ? defer_n : (pn | defer_n);
      if (defer_a && !drop_a)
        pjdo_a <= jdo;
      if (defer_b && !drop_b)
        pjdo_b <= jdo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
      rd_inc        <= 1'b0;
      av_reg_q      <= 1'b0;
      av_off_q      <= '0;
    end else begin
      monitor_go    <= srv_a & a_jdo[35];
      monitor_ready <= (monitor_ready & ~clr_st) | set_rdy;
      monitor_error <= (monitor_error & ~clr_st) | set_err;
      if (is_idle)
        rd_inc <= srv_n;
      if (srv_a)
        MonAReg <= a_jdo[ADDR_W+9:10];
      else if (srv_b || (state == J_CAP && rd_inc))
        MonAReg <= MonAReg + ONE;
      if (state == J_CAP)
        MonDReg <= ram_q[31:0];
      if (av_rd_acc) begin
        av_reg_q <= av_address[ADDR_W];
        av_off_q <= av_address[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_video_system_cpu_ocimem_access.sv
// Randomized and directed bench for the OCI debug RAM block,
// scored against an array-based model of the memory and monitor registers.
module tb_video_system_cpu_ocimem_access;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic          take_no_action_ocimem_a;
  logic [AW:0]   av_address;
  logic          av_read;
  logic          av_write;
  logic [31:0]   av_writedata;
  logic          debugaccess;
  logic [31:0]   av_readdata;
  logic          av_waitrequest;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready;
  logic          monitor_error;
  logic          monitor_go;

  video_system_cpu_ocimem_access #(.ADDR_W(AW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .av_address             (av_address),
    .av_read                (av_read),
    .av_write               (av_write),
    .av_writedata           (av_writedata),
    .debugaccess            (debugaccess),
    .av_readdata            (av_readdata),
    .av_waitrequest         (av_waitrequest),
    .MonDReg                (MonDReg),
    .MonAReg                (MonAReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .monitor_go             (monitor_go)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem_m [DEPTH];
  logic [AW-1:0] marg;
  logic [31:0]   mdreg;
  logic          rdy, err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status();
    chk("ready", 32'(monitor_ready), 32'(rdy));
    chk("error", 32'(monitor_error), 32'(err));
  endtask

  task automatic jtag_a(input logic [AW-1:0] a, input logic c,
                        input logic g, input logic r);
    jdo          = '0;
    jdo[AW+9:10] = a;
    jdo[9:0]     = 10'($urandom);
    jdo[34]      = c;
    jdo[35]      = g;
    jdo[36]      = r;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    marg = a;
    if (c) begin
      rdy = 1'b0;
      err = 1'b0;
    end
    chk("go_pulse", 32'(monitor_go), 32'(g));
    tick();
    chk("go_one_cycle", 32'(monitor_go), 32'(0));
    if (r) begin
      tick();
      mdreg = mem_m[a];
      chk("a_rd_data", MonDReg, mdreg);
    end
    chk("a_addr", 32'(MonAReg), 32'(marg));
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo       = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    mem_m[marg] = d;
    marg = marg + 8'd1;
    chk("b_addr", 32'(MonAReg), 32'(marg));
  endtask

  task automatic jtag_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    tick();
    mdreg = mem_m[marg];
    marg  = marg + 8'd1;
    chk("n_rd_data", MonDReg, mdreg);
    chk("n_addr", 32'(MonAReg), 32'(marg));
  endtask

  task automatic av_wr(input logic sp, input logic [AW-1:0] off,
                       input logic [31:0] d, input logic dbg);
    av_address   = {sp, off};
    av_writedata = d;
    debugaccess  = dbg;
    av_write     = 1'b1;
    #1;
    chk("av_wr_wait", 32'(av_waitrequest), 32'(0));
    tick();
    av_write = 1'b0;
    if (sp && off == 0) begin
      rdy = rdy | d[0];
      err = err | d[1];
    end
    if (!sp && dbg)
      mem_m[off] = d;
  endtask

  task automatic av_rd(input logic sp, input logic [AW-1:0] off,
                       input logic with_b, input logic [31:0] bd,
                       input int exp_waits);
    logic [31:0] data;
    logic [31:0] exp;
    int waits;
    bit got;
    waits = 0;
    got   = 0;
    data  = '0;
    av_address = {sp, off};
    av_read    = 1'b1;
    if (with_b) begin
      jdo       = '0;
      jdo[34:3] = bd;
      take_action_ocimem_b = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (!av_waitrequest) begin
        data = av_readdata;
        got  = 1;
      end else begin
        waits++;
      end
      tick();
      take_action_ocimem_b = 1'b0;
    end
    av_read = 1'b0;
    if (with_b) begin
      mem_m[marg] = bd;
      marg = marg + 8'd1;
    end
    if (!sp)       exp = mem_m[off];
    else if (off == 0) exp = {30'b0, err, rdy};
    else if (off == 1) exp = mdreg;
    else           exp = '0;
    chk("av_rd_done", 32'(got), 32'(1));
    chk("av_rd_data", data, exp);
    chk("av_rd_waits", 32'(waits), 32'(exp_waits));
    chk("av_rd_idle_zero", av_readdata, 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] m0;
    logic [AW-1:0] ra;
    logic [31:0]   rd;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    av_address = '0;
    av_read = 1'b0;
    av_write = 1'b0;
    av_writedata = '0;
    debugaccess = 1'b0;
    marg = '0;
    mdreg = '0;
    rdy = 1'b0;
    err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_mondreg", MonDReg, 32'(0));
    chk("rst_monareg", 32'(MonAReg), 32'(0));
    chk("rst_go", 32'(monitor_go), 32'(0));
    chk("rst_wait", 32'(av_waitrequest), 32'(0));
    chk("rst_rdata", av_readdata, 32'(0));
    chk_status();
    tick();

    jtag_a(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      jtag_b($urandom);

    jtag_a(8'h10, 1'b0, 1'b0, 1'b0);
    jtag_b(32'hDEADBEEF);
    jtag_b(32'h12345678);
    chk("plan_addr_12", 32'(MonAReg), 32'h12);
    av_rd(1'b0, 8'h10, 1'b0, '0, 1);

    jtag_a(8'h10, 1'b0, 1'b0, 1'b1);
    chk("plan_rd_dead", MonDReg, 32'hDEADBEEF);
    jtag_n();
    chk("plan_n_addr_11", 32'(MonAReg), 32'h11);

    jtag_a(8'hFF, 1'b0, 1'b0, 1'b0);
    jtag_b(32'hA5A5_0FF0);
    chk("wrap_addr", 32'(MonAReg), 32'h00);
    av_rd(1'b0, 8'hFF, 1'b0, '0, 1);

    jtag_a(8'h20, 1'b0, 1'b0, 1'b0);
    av_rd(1'b0, 8'h11, 1'b1, 32'hCAFE_F00D, 2);
    av_rd(1'b0, 8'h20, 1'b0, '0, 1);

    av_wr(1'b1, 8'h00, 32'h3, 1'b0);
    chk_status();
    av_rd(1'b1, 8'h00, 1'b0, '0, 1);
    jtag_a(8'h40, 1'b1, 1'b0, 1'b0);
    chk_status();
    jtag_a(8'h41, 1'b0, 1'b1, 1'b0);
    av_rd(1'b1, 8'h01, 1'b0, '0, 1);
    av_rd(1'b1, 8'h05, 1'b0, '0, 1);

    av_wr(1'b0, 8'h30, 32'h0BAD_0BAD, 1'b0);
    av_rd(1'b0, 8'h30, 1'b0, '0, 1);
    av_wr(1'b0, 8'h30, 32'h600D_600D, 1'b1);
    av_rd(1'b0, 8'h30, 1'b0, '0, 1);

    // Back-to-back no_action strobes: one serviced, one deferred, one dropped.
    m0 = MonAReg;
    take_no_action_ocimem_a = 1'b1;
    repeat (3) tick();
    take_no_action_ocimem_a = 1'b0;
    repeat (6) tick();
    mdreg = mem_m[m0 + 8'd1];
    marg  = m0 + 8'd2;
    err   = 1'b1;
    chk("pend_data", MonDReg, mdreg);
    chk("pend_addr", 32'(MonAReg), 32'(marg));
    chk_status();
    jtag_a(8'h00, 1'b1, 1'b0, 1'b0);
    chk_status();

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rd = $urandom;
      case ($urandom_range(0, 5))
        0: jtag_a(ra, 1'($urandom), 1'($urandom), 1'($urandom));
        1: jtag_b(rd);
        2: jtag_n();
        3: av_wr(1'b0, ra, rd, 1'($urandom));
        4: av_wr(1'b1, 8'($urandom_range(0, 2)), rd, 1'b0);
        default: av_rd(1'($urandom), 8'($urandom_range(0, 3)),
                       1'b0, '0, 1);
      endcase
      chk_status();
    end

`ifdef VIDEO_SYSTEM_CPU_OCIMEM_PARITY_EN
    jtag_a(8'h00, 1'b1, 1'b0, 1'b0);
    dut.mem[5][32] = ~dut.mem[5][32];
    av_rd(1'b0, 8'h05, 1'b0, '0, 1);
    err = 1'b1;
    chk_status();
`endif

    // Reset during a JTAG read with a deferred write queued behind it.
    jtag_a(8'h00, 1'b0, 1'b0, 1'b0);
    av_wr(1'b1, 8'h00, 32'h3, 1'b0);
    jdo = '0;
    jdo[AW+9:10] = 8'h22;
    jdo[36] = 1'b1;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    rdy = 1'b0;
    err = 1'b0;
    chk("midrst_mondreg", MonDReg, 32'(0));
    chk("midrst_monareg", 32'(MonAReg), 32'(0));
    chk_status();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
